// File: rtl/psram_frame_writer.sv
// Packs an RGB332 pixel stream into 16-bit words, buffers them and burst-writes them to PSRAM.
// Optional build macro PSRAM_WR_STATS_EN adds the saturating stall_cnt output.
module psram_frame_writer #(
    parameter int unsigned BURST_LEN   = 128,
    parameter int unsigned FIFO_AW     = 8,
    parameter int unsigned FRAME_WORDS = 153600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic        ctrlr_good,
    input  logic        op_begun,
    input  logic        data_ok,
    output logic        req_access,
    output logic        wr,
    output logic        burst,
    output logic [22:0] addr,
    output logic [15:0] wdata,
    output logic        sync_err
`ifdef PSRAM_WR_STATS_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int unsigned FifoDepth = 1 << FIFO_AW;
    localparam int unsigned CntW      = FIFO_AW + 1;
    localparam int unsigned BurstW    = $clog2(BURST_LEN) + 1;
    localparam logic [18:0] LastAddr  = 19'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitFill,
        StStart,
        StWaitOk,
        StBurst,
        StDone
    } state_e;

    state_e state_q, state_d;

    // FIFO entries: {sof tag, even pixel, odd pixel}
    logic [16:0]        fifo_mem [FifoDepth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    fifo_count_q;
    logic               fifo_full;
    logic [16:0]        fifo_head;

    logic [7:0]         hi_q;
    logic               hi_sof_q, hi_valid_q;
    logic               ready_en_q;
    logic               fill_ok_q;
    logic               inc_wait_q;
    logic [BurstW-1:0]  pop_cnt_q;
    logic [18:0]        addr_mem_q;

    logic               pix_accept, push, pop, last_pop;
    logic [16:0]        push_word;

    assign fifo_full  = fifo_count_q == CntW'(FifoDepth);
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign pix_ready  = ready_en_q && (!fifo_full || !hi_valid_q);
    assign pix_accept = pix_valid && pix_ready;
    // A pending high byte is flushed either by its partner or, padded, by a new sof byte.
    assign push       = pix_accept && hi_valid_q;
    assign push_word  = {hi_sof_q, hi_q, (pix_sof ? 8'h00 : pix_data)};
    assign pop        = (state_q == StBurst) && inc_wait_q;
    assign last_pop   = pop && (pop_cnt_q == BurstW'(BURST_LEN - 1));

    assign addr  = {4'b0000, addr_mem_q};
    assign wdata = burst ? fifo_head[15:0] : 16'h0000;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (ctrlr_good) state_d = StWaitFill;
            StWaitFill: begin
                if (!ctrlr_good)    state_d = StIdle;
                else if (fill_ok_q) state_d = StStart;
            end
            StStart:    if (op_begun) state_d = StWaitOk;
            StWaitOk:   if (data_ok) state_d = StBurst;
            StBurst:    if (last_pop) state_d = StDone;
            StDone:     state_d = StWaitFill;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_mem[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            hi_q         <= '0;
            hi_sof_q     <= 1'b0;
            hi_valid_q   <= 1'b0;
            ready_en_q   <= 1'b0;
            fill_ok_q    <= 1'b0;
            inc_wait_q   <= 1'b0;
            pop_cnt_q    <= '0;
            addr_mem_q   <= '0;
            req_access   <= 1'b0;
            wr           <= 1'b0;
            burst        <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;

            if (pix_accept) begin
                if (!hi_valid_q || pix_sof) begin
                    hi_q       <= pix_data;
                    hi_sof_q   <= pix_sof;
                    hi_valid_q <= 1'b1;
                end else begin
                    hi_valid_q <= 1'b0;
                end
            end

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            fifo_count_q <= fifo_count_q + CntW'(push) - CntW'(pop);
            // Registered threshold keeps the first wr two clocks behind the filling push.
            fill_ok_q    <= fifo_count_q >= CntW'(BURST_LEN);

            state_q    <= state_d;
            req_access <= state_d inside {StStart, StWaitOk, StBurst};
            wr         <= state_d == StStart;
            burst      <= state_d == StBurst;
            sync_err   <= pop && fifo_head[16] && (pop_cnt_q != '0);

            if (state_q == StWaitFill && state_d == StStart && fifo_head[16]) begin
                addr_mem_q <= '0;
            end

            if (state_q != StBurst && state_d == StBurst) begin
                inc_wait_q <= 1'b0;
                pop_cnt_q  <= '0;
            end else if (state_q == StBurst) begin
                inc_wait_q <= !inc_wait_q;
            end

            if (pop) begin
                pop_cnt_q  <= pop_cnt_q + 1'b1;
                addr_mem_q <= (addr_mem_q == LastAddr) ? 19'd0 : addr_mem_q + 1'b1;
            end
        end
    end

`ifdef PSRAM_WR_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (pix_valid && !pix_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
